// File: rtl/alu_decode_stage.sv
// Decode/issue stage ahead of the RV32I ALU: decodes an instruction into ALU
// control, operands, immediate and enables, and holds the result in a
// single-entry valid/ready pipeline register with a synchronous flush.
module alu_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [2:0]      alu_ctrl_o,
  output logic [XLEN-1:0] src_a_o,
  output logic [XLEN-1:0] src_b_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [4:0]      rd_o,
  output logic            reg_write_o,
  output logic            mem_write_o,
  output logic            mem_read_o,
  output logic            branch_o,
  output logic            illegal_o
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I_ARITH = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  typedef struct packed {
    alu_op_e         alu_op;
    logic [XLEN-1:0] src_b;
    logic            reg_write;
    logic            mem_write;
    logic            mem_read;
    logic            branch;
    logic            illegal;
  } decode_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  decode_t         dec;
  logic            load;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};

  // Accept only when the slot is free or being drained, and never during flush.
  assign in_ready_o = (!out_valid_o || out_ready_i) && !flush_i;
  assign load       = in_valid_i && in_ready_o;

  // Combinational decode of the incoming instruction.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    dec           = '0;
    dec.alu_op    = ALU_ADD;
    dec.src_b     = rs2_data_i;
    unique case (opcode)
      OP_R, OP_I_ARITH: begin
        dec.src_b     = (opcode == OP_R) ? rs2_data_i : imm_i;
        dec.reg_write = 1'b1;
        unique case (funct3)
          3'b000:  dec.alu_op = (opcode == OP_R && instr_i[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  dec.alu_op = ALU_SLT;
          3'b110:  dec.alu_op = ALU_OR;
          3'b111:  dec.alu_op = ALU_AND;
          default: begin
            dec.illegal   = 1'b1;
            dec.reg_write = 1'b0;
          end
        endcase
      end
      OP_LOAD: begin
        dec.src_b     = imm_i;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
      end
      OP_STORE: begin
        dec.src_b     = imm_s;
        dec.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        dec.alu_op = ALU_SUB;
        dec.branch = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Valid bit: flush wins, then load, then drain; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
    end else if (flush_i) begin
      // NOTE: sequential state uses non-blocking assignment so all registers
      // see the same pre-edge values.
      out_valid_o <= 1'b0;
    end else if (load) begin
      out_valid_o <= 1'b1;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  // Payload registers: capture on load, hold otherwise (including drain/flush).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload is reset too, because every output must read 0 in reset.
      alu_ctrl_o   <= ALU_ADD;
      src_a_o      <= '0;
      src_b_o      <= '0;
      store_data_o <= '0;
      rd_o         <= '0;
      reg_write_o  <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_read_o   <= 1'b0;
      branch_o     <= 1'b0;
      illegal_o    <= 1'b0;
    end else if (load) begin
      alu_ctrl_o   <= dec.alu_op;
      src_a_o      <= rs1_data_i;
      src_b_o      <= dec.src_b;
      store_data_o <= rs2_data_i;
      rd_o         <= instr_i[11:7];
      reg_write_o  <= dec.reg_write;
      mem_write_o  <= dec.mem_write;
      mem_read_o   <= dec.mem_read;
      branch_o     <= dec.branch;
      illegal_o    <= dec.illegal;
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed testbench for alu_decode_stage with hand-computed expectations.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] src_a_o;
  logic [31:0] src_b_o;
  logic [31:0] store_data_o;
  logic [4:0]  rd_o;
  logic        reg_write_o;
  logic        mem_write_o;
  logic        mem_read_o;
  logic        branch_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  alu_decode_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .alu_ctrl_o  (alu_ctrl_o),
    .src_a_o     (src_a_o),
    .src_b_o     (src_b_o),
    .store_data_o(store_data_o),
    .rd_o        (rd_o),
    .reg_write_o (reg_write_o),
    .mem_write_o (mem_write_o),
    .mem_read_o  (mem_read_o),
    .branch_o    (branch_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
    instr_i    = instr;
    rs1_data_i = rs1;
    rs2_data_i = rs2;
  endtask

  task automatic check_flags(input string tag, input logic rw, input logic mw,
                             input logic mr, input logic br, input logic il);
    check({tag, ".reg_write"}, 32'(reg_write_o), 32'(rw));
    check({tag, ".mem_write"}, 32'(mem_write_o), 32'(mw));
    check({tag, ".mem_read"},  32'(mem_read_o),  32'(mr));
    check({tag, ".branch"},    32'(branch_o),    32'(br));
    check({tag, ".illegal"},   32'(illegal_o),   32'(il));
  endtask

  initial begin
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    drive(32'h0, 32'h0, 32'h0);
    #12;
    check("reset.out_valid", 32'(out_valid_o), 32'd0);
    check("reset.alu_ctrl",  32'(alu_ctrl_o),  32'd0);
    check("reset.src_b",     src_b_o,          32'd0);
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #5 rst_n = 1'b1;
    tick();

    // add x3,x1,x2
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    drive(32'h002081B3, 32'd5, 32'd7);
    #1 check("add.in_ready", 32'(in_ready_o), 32'd1);
    tick();
    check("add.out_valid",  32'(out_valid_o), 32'd1);
    check("add.alu_ctrl",   32'(alu_ctrl_o),  32'b000);
    check("add.src_a",      src_a_o,          32'd5);
    check("add.src_b",      src_b_o,          32'd7);
    check("add.rd",         32'(rd_o),        32'd3);
    check("add.store_data", store_data_o,     32'd7);
    check_flags("add", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // sub x3,x1,x2 (back-to-back load with drain)
    drive(32'h402081B3, 32'd5, 32'd7);
    tick();
    check("sub.out_valid", 32'(out_valid_o), 32'd1);
    check("sub.alu_ctrl",  32'(alu_ctrl_o),  32'b001);

    // addi x1,x0,-1
    drive(32'hFFF00093, 32'd5, 32'd9);
    tick();
    check("addi.alu_ctrl", 32'(alu_ctrl_o), 32'b000);
    check("addi.src_b",    src_b_o,         32'hFFFFFFFF);
    check("addi.rd",       32'(rd_o),       32'd1);

    // addi with instr[30]=1 must stay ADD
    drive(32'h40000093, 32'd5, 32'd9);
    tick();
    check("addi30.alu_ctrl", 32'(alu_ctrl_o), 32'b000);
    check("addi30.src_b",    src_b_o,         32'h00000400);

    // slti x1,x0,5
    drive(32'h00502093, 32'd5, 32'd9);
    tick();
    check("slti.alu_ctrl", 32'(alu_ctrl_o), 32'b101);
    check("slti.src_b",    src_b_o,         32'd5);

    // or / and R-type
    drive(32'h0020E1B3, 32'd5, 32'd7);
    tick();
    check("or.alu_ctrl", 32'(alu_ctrl_o), 32'b011);
    drive(32'h0020F1B3, 32'd5, 32'd7);
    tick();
    check("and.alu_ctrl", 32'(alu_ctrl_o), 32'b010);

    // lw x5,8(x1)
    drive(32'h0080A283, 32'd5, 32'd7);
    tick();
    check("lw.alu_ctrl", 32'(alu_ctrl_o), 32'b000);
    check("lw.src_b",    src_b_o,         32'd8);
    check("lw.rd",       32'(rd_o),       32'd5);
    check_flags("lw", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // beq x1,x2
    drive(32'h00208063, 32'd5, 32'h55);
    tick();
    check("beq.alu_ctrl", 32'(alu_ctrl_o), 32'b001);
    check("beq.src_b",    src_b_o,         32'h55);
    check_flags("beq", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // sw x2,-4(x1)
    drive(32'hFE20AE23, 32'd5, 32'hAB);
    tick();
    check("sw.alu_ctrl",   32'(alu_ctrl_o), 32'b000);
    check("sw.src_b",      src_b_o,         32'hFFFFFFFC);
    check("sw.store_data", store_data_o,    32'hAB);
    check_flags("sw", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stall three cycles with a new instruction waiting
    out_ready_i = 1'b0;
    drive(32'h002081B3, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      #1 check("stall.in_ready", 32'(in_ready_o), 32'd0);
      tick();
      check("stall.out_valid",  32'(out_valid_o), 32'd1);
      check("stall.src_b",      src_b_o,          32'hFFFFFFFC);
      check("stall.store_data", store_data_o,     32'hAB);
      check("stall.mem_write",  32'(mem_write_o), 32'd1);
    end
    // Release: waiting add loads with no bubble
    out_ready_i = 1'b1;
    #1 check("release.in_ready", 32'(in_ready_o), 32'd1);
    tick();
    check("release.out_valid", 32'(out_valid_o), 32'd1);
    check("release.src_a",     src_a_o,          32'd1);
    check("release.src_b",     src_b_o,          32'd2);
    check_flags("release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Flush with a held entry and a pending instruction
    out_ready_i = 1'b0;
    flush_i     = 1'b1;
    drive(32'h402081B3, 32'd3, 32'd4);
    #1 check("flush.in_ready", 32'(in_ready_o), 32'd0);
    tick();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("flush.out_valid", 32'(out_valid_o), 32'd0);
    #1 check("flush.in_ready_after", 32'(in_ready_o), 32'd1);
    tick();
    check("flush.not_captured", 32'(out_valid_o), 32'd0);

    // Illegal opcode 0x7F
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    drive(32'h0000007F, 32'd1, 32'd2);
    tick();
    check("ill_op.out_valid", 32'(out_valid_o), 32'd1);
    check("ill_op.alu_ctrl",  32'(alu_ctrl_o),  32'b000);
    check_flags("ill_op", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Illegal R-type funct3=001
    drive(32'h00209133, 32'd1, 32'd2);
    tick();
    check("ill_f3.alu_ctrl", 32'(alu_ctrl_o), 32'b000);
    check_flags("ill_f3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Drain: valid drops, payload holds
    in_valid_i = 1'b0;
    tick();
    check("drain.out_valid", 32'(out_valid_o), 32'd0);
    check("drain.src_b",     src_b_o,          32'd2);
    check("drain.illegal",   32'(illegal_o),   32'd1);

    // Reset mid-stall clears immediately
    in_valid_i  = 1'b1;
    out_ready_i = 1'b0;
    drive(32'h002081B3, 32'd5, 32'd7);
    tick();
    in_valid_i = 1'b0;
    check("pre_rst.out_valid", 32'(out_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.out_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst.src_a",     src_a_o,          32'd0);
    check("mid_rst.reg_write", 32'(reg_write_o), 32'd0);
    #2 rst_n = 1'b1;
    in_valid_i = 1'b1;
    tick();
    check("post_rst.out_valid", 32'(out_valid_o), 32'd1);
    check("post_rst.src_b",     src_b_o,          32'd7);
    in_valid_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
